uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_baud.sv | 29 ++
 rtl/uart_tx.sv | 87 ++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, field widths and the default
// baud divisor, common to transmitter and receiver.
package uart_pkg;

    localparam int unsigned CNT_W  = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    // 50 MHz system clock / 9600 baud
    localparam logic [CNT_W-1:0] BPS_DEFAULT = 13'd5208;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period counter: runs 0..BPS_CNT-1 while enabled, held at 0 otherwise.
module uart_tx_baud
    import uart_pkg::*;
#(
    parameter logic [12:0] BPS_CNT = BPS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_end
);

    logic [CNT_W-1:0] count;

    // Decoded from the count register only; count idles at 0 and BPS_CNT >= 2,
    // so bit_end can never assert while disabled.
    assign bit_end = (count == BPS_CNT - 13'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 13'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, with
// busy/done handshake and fully registered outputs.
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [12:0] BPS_CNT = BPS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_state_e       state;
    logic [DATA_W-1:0] shift;
    logic [IDX_W-1:0]  idx;
    logic              bit_end;
    logic              baud_en;

    // Counter runs in every state except IDLE, so it starts from 0 on the
    // first cycle of the start bit.
    assign baud_en = (state != IDLE);

    uart_tx_baud #(
        .BPS_CNT (BPS_CNT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (baud_en),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            idx     <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift   <= tx_data;
                        idx     <= '0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    // tx presents the next bit while the register shifts under it
                    if (bit_end) begin
                        shift <= shift >> 1;
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: a fast instance (BPS_CNT=4) and a default-rate
// instance are compared every cycle against a frame-offset reference model.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    // Model: cycles since acceptance edge per instance (-1 = never started).
    int         bps [2] = '{4, 5208};
    int         off [2] = '{-1, -1};
    logic [7:0] mbyte [2];

    uart_tx #(.BPS_CNT(13'd4)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_start(start_a), .tx_data(data_a),
        .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_tx dut_b (
        .clk(clk), .rst_n(rst_n), .tx_start(start_b), .tx_data(data_b),
        .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected {tx, busy, done} from the frame offset: bit k occupies offsets
    // k*B+1 .. (k+1)*B; done is the single cycle after the stop bit.
    function automatic logic [2:0] exp_out(input int i);
        int f, b;
        f = 10 * bps[i];
        if (off[i] < 1) return 3'b100;
        if (off[i] > f) return {1'b1, 1'b0, (off[i] == f + 1)};
        b = (off[i] - 1) / bps[i];
        if (b == 0) return 3'b010;
        if (b == 9) return 3'b110;
        return {mbyte[i][b-1], 1'b1, 1'b0};
    endfunction

    function automatic void step(input int i, input logic st, input logic [7:0] d);
        if ((off[i] < 0 || off[i] > 10 * bps[i]) && st) begin
            off[i]   = 1;
            mbyte[i] = d;
        end else if (off[i] >= 0 && off[i] < 1000000) begin
            off[i]++;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off[0] = -1;
            off[1] = -1;
        end else begin
            step(0, start_a, data_a);
            step(1, start_b, data_b);
        end
    end

    always @(negedge clk) begin
        chk("cyc_a", 32'({tx_a, busy_a, done_a}), 32'(exp_out(0)));
        chk("cyc_b", 32'({tx_b, busy_b, done_b}), 32'(exp_out(1)));
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d);
        start_a = 1'b1;
        data_a  = d;
        cyc(1);
        start_a = 1'b0;
    endtask

    int base;

    initial begin
        cyc(3);
        chk("rst_tx",   32'(tx_a),   32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        cyc(3);

        // 0x55 single frame, 41-cycle latency to done
        base = done_cnt_a;
        send_a(8'h55);
        cyc(45);
        chk("f55_done_cnt", 32'(done_cnt_a - base), 32'd1);

        // tx_start held: 0xA5 then 0x3C back to back
        base = done_cnt_a;
        start_a = 1'b1;
        data_a  = 8'hA5;
        cyc(1);
        data_a = 8'h3C;
        cyc(41);
        start_a = 1'b0;
        cyc(45);
        chk("b2b_done_cnt", 32'(done_cnt_a - base), 32'd2);

        // Start pulse mid-frame is ignored
        base = done_cnt_a;
        send_a(8'h00);
        cyc(9);
        send_a(8'hFF);
        cyc(45);
        chk("ign_done_cnt", 32'(done_cnt_a - base), 32'd1);

        // Async reset during data bit 3
        send_a(8'($urandom));
        cyc(17);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx",   32'(tx_a),   32'd1);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_done", 32'(done_a), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk("arst_idle", 32'({tx_a, busy_a}), 32'b10);
        base = done_cnt_a;
        send_a(8'h96);
        cyc(45);
        chk("arst_new_done", 32'(done_cnt_a - base), 32'd1);

        // Data bus churn during an in-flight 0xC3 frame
        send_a(8'hC3);
        for (int k = 0; k < 45; k++) begin
            data_a = 8'($urandom);
            cyc(1);
        end

        // Random traffic
        for (int r = 0; r < 40; r++) begin
            start_a = 1'b1;
            data_a  = 8'($urandom);
            cyc(int'($urandom_range(1, 3)));
            start_a = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 50)); g++) begin
                data_a = 8'($urandom);
                cyc(1);
            end
        end
        cyc(45);

        // Default-rate frame of 0x00
        base = done_cnt_b;
        start_b = 1'b1;
        data_b  = 8'h00;
        cyc(1);
        start_b = 1'b0;
        data_b  = 8'hFF;
        cyc(52090);
        chk("def_done_cnt", 32'(done_cnt_b - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
